// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle between a pattern transmitter and whatever drives it.
// The transmitter takes the slave side. The stimulus or controller takes the master side.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             sequence_out;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_n,
    input  sequence_out, bit_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_n,
    output sequence_out, bit_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter that drives a sequence detector's input.
// It shifts a latched pattern out MSB-first, repeats it, optionally inserts idle gaps, and then pulses done.
module seq_pattern_tx #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 0
) (
  input  logic              clk,
  input  logic              reset,
  seq_pattern_tx_if.slave   bus
);
  localparam int BW = $clog2(PAT_W);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_shift;
  logic [PAT_W-1:0] r_pat;
  logic [BW-1:0]    r_bitcnt;
  logic [CNT_W-1:0] r_rep;
  logic [GW-1:0]    r_gapcnt;
  logic             r_seq;
  logic             r_vld;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_pat    <= '0;
      r_bitcnt <= '0;
      r_rep    <= '0;
      r_gapcnt <= '0;
      r_seq    <= 1'b0;
      r_vld    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Every output defaults low. Each state raises only the outputs it owns.
      r_seq  <= 1'b0;
      r_vld  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_shift  <= bus.pattern;
              r_pat    <= bus.pattern;
              r_rep    <= (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
              r_bitcnt <= BIT_LAST;
              r_state  <= SHIFT;
            end
          end
          SHIFT: begin
            r_seq   <= r_shift[PAT_W-1];
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
            r_shift <= r_shift << 1;
            if (r_bitcnt == '0) begin
              if (r_rep != '0) r_rep <= r_rep - CNT_W'(1);
              // A count above one means at least one more repetition follows this one.
              if (r_rep > CNT_W'(1)) begin
                r_bitcnt <= BIT_LAST;
                if (GAP_CYC == 0) begin
                  r_shift <= r_pat;
                end else begin
                  r_gapcnt <= GAP_LAST;
                  r_state  <= GAP;
                end
              end else begin
                r_state <= DONE;
              end
            end else begin
              r_bitcnt <= r_bitcnt - BW'(1);
            end
          end
          GAP: begin
            r_busy <= 1'b1;
            // Reload on the final gap cycle so that the next edge carries the pattern MSB.
            if (r_gapcnt == '0) begin
              r_shift  <= r_pat;
              r_bitcnt <= BIT_LAST;
              r_state  <= SHIFT;
            end else begin
              r_gapcnt <= r_gapcnt - GW'(1);
            end
          end
          DONE: begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sequence_out = r_seq;
  assign bus.bit_valid    = r_vld;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed scoreboard bench for seq_pattern_tx, with back-to-back (GAP_CYC=0) and gapped (GAP_CYC=2) instances.
module tb_seq_pattern_tx;
  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic seq;
    logic vld;
    logic busy;
    logic done;
  } obs_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  obs_t  q0[$];
  obs_t  q2[$];
  int    checks = 0;
  int    failures = 0;
  string phase = "reset";

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus0 ();
  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus2 ();

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  always #5 clk = ~clk;

  task automatic drive(input logic st, input logic ab, input logic [3:0] pat, input logic [3:0] rep);
    bus0.start = st; bus0.abort = ab; bus0.pattern = pat; bus0.repeat_n = rep;
    bus2.start = st; bus2.abort = ab; bus2.pattern = pat; bus2.repeat_n = rep;
  endtask

  task automatic push(input int which, input obs_t v);
    if (which == 0) q0.push_back(v);
    else            q2.push_back(v);
  endtask

  // Expected per-cycle outputs from the accepting edge N through the done pulse.
  task automatic push_tx(input int which, input int gap, input logic [3:0] pat, input int reps);
    push(which, 4'b0000);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < PAT_W; k++) push(which, {pat[PAT_W-1-k], 3'b110});
      if (r < reps - 1)
        for (int g = 0; g < gap; g++) push(which, 4'b0010);
    end
    push(which, 4'b0001);
  endtask

  task automatic compare(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%b expected=%b (seq,vld,busy,done)", phase, tag, obs, exp);
    end
  endtask

  task automatic step();
    obs_t e0, e2;
    @(posedge clk);
    #1;
    e0 = '0;
    e2 = '0;
    if (q0.size() != 0) e0 = q0.pop_front();
    if (q2.size() != 0) e2 = q2.pop_front();
    compare("gap0", {bus0.sequence_out, bus0.bit_valid, bus0.busy, bus0.done}, e0);
    compare("gap2", {bus2.sequence_out, bus2.bit_valid, bus2.busy, bus2.done}, e2);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() != 0 || q2.size() != 0) && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    assert (q0.size() == 0 && q2.size() == 0) else begin
      failures++;
      $error("FAIL %s/drain observed=%0d,%0d expected=0,0 entries left", phase, q0.size(), q2.size());
    end
    step();
    step();
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'b0000, 4'd0);
    // Hold reset for 3 cycles, then release. All outputs must stay low.
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    phase = "single";
    drive(1'b1, 1'b0, 4'b1011, 4'd1);
    push_tx(0, 0, 4'b1011, 1);
    push_tx(2, 2, 4'b1011, 1);
    step();
    drive(1'b0, 1'b0, 4'b1011, 4'd1);
    drain();

    phase = "rep3";
    drive(1'b1, 1'b0, 4'b1011, 4'd3);
    push_tx(0, 0, 4'b1011, 3);
    push_tx(2, 2, 4'b1011, 3);
    step();
    drive(1'b0, 1'b0, 4'b1011, 4'd3);
    drain();

    phase = "rep2";
    drive(1'b1, 1'b0, 4'b1011, 4'd2);
    push_tx(0, 0, 4'b1011, 2);
    push_tx(2, 2, 4'b1011, 2);
    step();
    drive(1'b0, 1'b0, 4'b1011, 4'd2);
    drain();

    // repeat_n=0 behaves as 1. A start and pattern change mid-run must not disturb the stream.
    phase = "rep0_midchg";
    drive(1'b1, 1'b0, 4'b1011, 4'd0);
    push_tx(0, 0, 4'b1011, 1);
    push_tx(2, 2, 4'b1011, 1);
    step();
    drive(1'b0, 1'b0, 4'b1011, 4'd0);
    step();
    drive(1'b1, 1'b0, 4'b0000, 4'd5);
    step();
    step();
    drive(1'b0, 1'b0, 4'b0000, 4'd5);
    drain();

    phase = "abort";
    drive(1'b1, 1'b0, 4'b1011, 4'd3);
    for (int w = 0; w < 2; w++) begin
      push(w * 2, 4'b0000);
      push(w * 2, 4'b1110);
      push(w * 2, 4'b0110);
    end
    step();
    drive(1'b0, 1'b0, 4'b1011, 4'd3);
    step();
    step();
    drive(1'b0, 1'b1, 4'b1011, 4'd3);
    step();
    drive(1'b0, 1'b0, 4'b1011, 4'd3);
    repeat (6) step();

    phase = "abort_vs_start";
    drive(1'b1, 1'b1, 4'b1111, 4'd1);
    step();
    drive(1'b0, 1'b0, 4'b1111, 4'd1);
    repeat (3) step();

    // Reset lands during the first gap cycle of the gapped instance.
    phase = "reset_mid_gap";
    drive(1'b1, 1'b0, 4'b1011, 4'd2);
    push(0, 4'b0000); push(2, 4'b0000);
    for (int k = 0; k < PAT_W; k++) begin
      push(0, {(k != 1), 3'b110});
      push(2, {(k != 1), 3'b110});
    end
    push(0, 4'b1110);
    push(2, 4'b0010);
    step();
    drive(1'b0, 1'b0, 4'b1011, 4'd2);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2) step();

    phase = "after_reset";
    drive(1'b1, 1'b0, 4'b1100, 4'd1);
    push_tx(0, 0, 4'b1100, 1);
    push_tx(2, 2, 4'b1100, 1);
    step();
    drive(1'b0, 1'b0, 4'b1100, 4'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter FSM. It is the driving end of the serial sequence-detector interface.
- On a start request it loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock, on sequence_out.
- It repeats the pattern a programmable number of times, with optional idle gaps, then pulses done.
- Used to stimulate and exercise sequence detectors in-system, driving their sequence input directly.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- CNT_W, 4, width of repeat-count input.
- GAP_CYC, 0, idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin transmission; sampled only in IDLE.
- abort  input  1  synchronous cancel; effective in any state.
- pattern  input  PAT_W  bit pattern; latched on accepted start.
- repeat_n  input  CNT_W  number of repetitions; latched on accepted start; 0 treated as 1.
- sequence_out  output  1  serial data bit (registered).
- bit_valid  output  1  high when sequence_out carries a pattern bit.
- busy  output  1  high while transmitting (SHIFT or GAP).
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- All outputs are registered.
- Reset (dominates start/abort): state=IDLE; sequence_out=0, bit_valid=0, busy=0, done=0; shift register, bit counter and repeat counter cleared.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: outputs 0.
  - On start=1 at edge N: latch pattern into the shift register and repeat_n (0 becomes 1) into the repeat counter; bit counter = PAT_W-1.
  - Enter SHIFT at edge N+1.
- SHIFT: after edge N+1+k, sequence_out = pattern[PAT_W-1-k], bit_valid=1, busy=1 (k = 0..PAT_W-1).
  - After the PAT_W-th bit, decrement the repeat counter.
  - If repetitions remain and GAP_CYC=0: reload the pattern and continue SHIFT with no bubble.
  - If repetitions remain and GAP_CYC>0: go to GAP.
  - Otherwise: go to DONE.
- GAP: sequence_out=0, bit_valid=0, busy=1 for exactly GAP_CYC cycles. Then SHIFT with the reloaded latched pattern.
- DONE: done=1, busy=0, bit_valid=0, sequence_out=0 for one cycle. Next state IDLE.
  - start is ignored in DONE. A new start is accepted in IDLE at the earliest one cycle after done.
- Timing for R reps (R>=1), gap G:
  - First bit visible after edge N+1.
  - Last bit visible after edge N + R*PAT_W + (R-1)*G.
  - done high after edge N + R*PAT_W + (R-1)*G + 1.
- start while busy: ignored. Latched pattern/repeat values are unaffected by input changes mid-transmission.
- abort=1 in SHIFT/GAP/DONE: next edge → IDLE, all outputs 0, no done pulse.
  - abort and start together in IDLE: abort wins, start ignored.
- reset mid-transmission: immediate return to reset values at that edge; no done.
- Counters: bit counter width clog2(PAT_W); repeat counter CNT_W bits. No wrap: repeat counter stops at terminal value.

Test Plan:
- Reset hold 3 cycles, then release → sequence_out=0, bit_valid=0, busy=0, done=0 throughout, state IDLE.
- PAT_W=4, pattern=4'b1011, repeat_n=1, start pulse at edge N → sequence_out 1,0,1,1 after edges N+1..N+4, bit_valid=1 on those cycles, done=1 only after N+5, busy low by N+5.
- pattern=4'b1011, repeat_n=3, GAP_CYC=0 → 12 contiguous valid bits 101110111011, done after edge N+13.
- Same pattern with GAP_CYC=2 and repeat_n=2 → bits 1011, two cycles bit_valid=0 with sequence_out=0, then 1011; done after edge N+11.
- repeat_n=0 → identical to repeat_n=1. start re-asserted during SHIFT and pattern changed to 4'b0000 mid-run → output stream unchanged.
- abort asserted after the 2nd bit → IDLE next edge, all outputs 0, no done. reset asserted mid-GAP → same; then a new start with 4'b1100 transmits cleanly.
